// File: rtl/disp_pkg.sv
// Shared types and constants for the display-sharing arbiter.
package disp_pkg;
  typedef enum logic {IDLE, SHOW} disp_state_t;

  localparam int DASH_CODE = 10000;
  localparam int HELO_CODE = 9999;

  // Dwell counter only has to reach HOLD_CYCLES-1.
  function automatic int dwell_w(input int hold);
    return (hold > 2) ? $clog2(hold) : 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/disp_share_arbiter_if.sv
// Requester-side bus of the display arbiter: requests/values in, owner and display value out.
interface disp_share_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0][31:0] value;
  logic [N_REQ-1:0]       grant;
  logic [31:0]            num_out;
  logic                   busy;

  modport master (output req, value, input grant, num_out, busy);
  modport slave  (input req, value, output grant, num_out, busy);
endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after i_last, with wrap-around.
module rr_pick
  import disp_pkg::*;
#(
  parameter int N_REQ = 3,
  localparam int IW   = idx_w(N_REQ)
)(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic             o_valid,
  output logic [IW-1:0]    o_pick
);
  logic [2*N_REQ-1:0] w_dbl;
  logic [2*N_REQ-1:0] w_mask;
  logic [2*N_REQ-1:0] w_hit;

  // Doubling the vector turns the wrap-around into a plain window last+1..last+N.
  always_comb begin
    w_dbl = {i_req, i_req};
    for (int i = 0; i < 2*N_REQ; i++)
      w_mask[i] = (i > int'(i_last)) && (i <= int'(i_last) + N_REQ);
    w_hit   = w_dbl & w_mask;
    o_valid = |i_req;
    o_pick  = '0;
    for (int i = 2*N_REQ-1; i >= 0; i--)
      if (w_hit[i]) o_pick = (i >= N_REQ) ? IW'(i - N_REQ) : IW'(i);
  end
endmodule

// File: rtl/disp_share_arbiter.sv
// Shares one 4-digit display between N_REQ requesters, round-robin with a minimum dwell per grant.
module disp_share_arbiter
  import disp_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int IDLE_CODE   = DASH_CODE
)(
  input  logic                 clk,
  input  logic                 rst_n,
  disp_share_arbiter_if.slave  bus
);
  localparam int              IW        = idx_w(N_REQ);
  localparam int              DW        = dwell_w(HOLD_CYCLES);
  localparam logic [DW-1:0]   DWELL_MAX = DW'(HOLD_CYCLES - 1);
  localparam logic [31:0]     IDLE_VAL  = 32'(IDLE_CODE);
  localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

  disp_state_t      r_state, w_state_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]    r_last,  w_last_nxt;
  logic [DW-1:0]    r_dwell, w_dwell_nxt;
  logic [31:0]      r_num,   w_num_nxt;

  logic [N_REQ-1:0] w_cand;
  logic             w_pend;
  logic [IW-1:0]    w_pick;
  logic             w_own_req;
  logic [31:0]      w_own_val;
  logic             w_done;

  // In IDLE grant is zero, so the same picker serves both first pick and handover.
  assign w_cand = bus.req & ~r_grant;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req   (w_cand),
    .i_last  (r_last),
    .o_valid (w_pend),
    .o_pick  (w_pick)
  );

  assign w_own_req = bus.req[r_last];
  assign w_own_val = bus.value[r_last];
  assign w_done    = (r_dwell == DWELL_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_dwell_nxt = r_dwell;
    w_num_nxt   = r_num;
    unique case (r_state)
      IDLE: begin
        w_num_nxt = IDLE_VAL;
        if (w_pend) begin
          w_state_nxt = SHOW;
          w_grant_nxt = ONE << w_pick;
          w_last_nxt  = w_pick;
          w_dwell_nxt = '0;
        end
      end
      SHOW: begin
        if (!w_done) w_dwell_nxt = r_dwell + 1'b1;
        // Negative values have no rendering; show dashes instead. Dropped owner freezes.
        if (w_own_req) w_num_nxt = w_own_val[31] ? IDLE_VAL : w_own_val;
        if (w_done) begin
          if (w_pend) begin
            w_grant_nxt = ONE << w_pick;
            w_last_nxt  = w_pick;
            w_dwell_nxt = '0;
          end else if (!w_own_req) begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_num_nxt   = IDLE_VAL;
            w_dwell_nxt = '0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= IW'(N_REQ - 1);
      r_dwell <= '0;
      r_num   <= IDLE_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_dwell <= w_dwell_nxt;
      r_num   <= w_num_nxt;
    end
  end

  assign bus.grant   = r_grant;
  assign bus.num_out = r_num;
  assign bus.busy    = (r_state == SHOW);
endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed bench for disp_share_arbiter (N_REQ=3, HOLD_CYCLES=4) with a cycle-level reference model.
module tb_disp_share_arbiter;
  localparam int N      = 3;
  localparam int HOLD   = 4;
  localparam int IDLE_V = 10000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  disp_share_arbiter_if #(.N_REQ(N)) bus ();

  disp_share_arbiter #(.N_REQ(N), .HOLD_CYCLES(HOLD), .IDLE_CODE(IDLE_V)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d", nm, act, act, exp);
  endtask

  // Reference model: owner (-1 = nobody), cycles held so far, shown value.
  int          m_owner = -1;
  int          m_last  = N - 1;
  int          m_held  = 0;
  logic [31:0] m_num   = IDLE_V;
  logic [N-1:0] m_others;

  function automatic int scan(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++) if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] shown(input logic [31:0] v);
    return ($signed(v) < 0) ? 32'(IDLE_V) : v;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_owner = -1; m_last = N - 1; m_held = 0; m_num = IDLE_V;
    end else if (m_owner < 0) begin
      if (bus.req != 0) begin
        m_owner = scan(bus.req, m_last); m_last = m_owner; m_held = 0;
      end
    end else begin
      m_others = bus.req & ~(N'(1) << m_owner);
      if (bus.req[m_owner]) m_num = shown(bus.value[m_owner]);
      if (m_held >= HOLD - 1) begin
        if (m_others != 0) begin
          m_owner = scan(m_others, m_owner); m_last = m_owner; m_held = 0;
        end else if (!bus.req[m_owner]) begin
          m_owner = -1; m_num = IDLE_V;
        end else m_held++;
      end else m_held++;
    end
  end

  logic [N-1:0] e_grant;
  initial forever begin
    @(negedge clk);
    e_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    chk("model_grant", 32'(bus.grant), 32'(e_grant));
    chk("model_num",   bus.num_out,    m_num);
    chk("model_busy",  32'(bus.busy),  32'(m_owner >= 0));
  end

  task automatic wait_idle(input string nm);
    int k = 0;
    while (bus.grant != 0 && k < 12) begin @(negedge clk); k++; end
    chk(nm, 32'(bus.grant), 32'(0));
  endtask

  initial begin
    bus.req   = 3'b111;
    bus.value = '0;
    rst_n     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_grant", 32'(bus.grant), 32'(0));
      chk("rst_num",   bus.num_out,    32'(10000));
      chk("rst_busy",  32'(bus.busy),  32'(0));
    end
    rst_n   = 1'b1;
    bus.req = 3'b000;

    // Single requester 1.
    @(negedge clk); bus.req = 3'b010; bus.value[1] = 1234;
    @(negedge clk);
    chk("r1_grant", 32'(bus.grant), 32'(3'b010));
    chk("r1_num0",  bus.num_out,    32'(10000));
    @(negedge clk); chk("r1_num", bus.num_out, 32'(1234));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("r1_hold_grant", 32'(bus.grant), 32'(3'b010));
      chk("r1_hold_num",   bus.num_out,    32'(1234));
    end
    bus.req = 3'b000;
    wait_idle("r1_idle");

    // Owner 0, requester 2 arrives one cycle after the grant.
    bus.req = 3'b001; bus.value[0] = 42; bus.value[2] = 777;
    @(negedge clk);
    chk("o0_grant_d0", 32'(bus.grant), 32'(3'b001));
    bus.req = 3'b101;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("o0_grant_dwell", 32'(bus.grant), 32'(3'b001));
      chk("o0_num",         bus.num_out,    32'(42));
    end
    @(negedge clk);
    chk("o0_switch_grant", 32'(bus.grant), 32'(3'b100));
    chk("o0_switch_num",   bus.num_out,    32'(42));
    @(negedge clk);
    chk("o2_num", bus.num_out, 32'(777));
    bus.req = 3'b000;
    wait_idle("o2_idle");

    // Owner 1 drops at dwell 1: value freezes until dwell completes.
    bus.req = 3'b010; bus.value[1] = 555;
    @(negedge clk); chk("d1_grant", 32'(bus.grant), 32'(3'b010));
    @(negedge clk); chk("d1_num",   bus.num_out,    32'(555));
    bus.req = 3'b000; bus.value[1] = 999;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("d1_frozen_grant", 32'(bus.grant), 32'(3'b010));
      chk("d1_frozen_num",   bus.num_out,    32'(555));
    end
    @(negedge clk);
    chk("d1_idle_grant", 32'(bus.grant), 32'(0));
    chk("d1_idle_num",   bus.num_out,    32'(10000));
    chk("d1_idle_busy",  32'(bus.busy),  32'(0));

    // Value sanitising on owner 2.
    bus.req = 3'b100; bus.value[2] = -5;
    @(negedge clk); chk("v_grant", 32'(bus.grant), 32'(3'b100));
    @(negedge clk); chk("v_neg",   bus.num_out,    32'(10000));
    bus.value[2] = 9999;
    @(negedge clk); chk("v_helo",  bus.num_out,    32'(9999));
    bus.value[2] = 12345;
    @(negedge clk); chk("v_dash",  bus.num_out,    32'(12345));
    bus.req = 3'b000;
    wait_idle("v_idle");

    // All three requesting: strict rotation, 4 cycles each.
    bus.value[0] = 11; bus.value[1] = 22; bus.value[2] = 33;
    bus.req = 3'b111;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk("rr_grant", 32'(bus.grant),
          (i < 4) ? 32'(1) : (i < 8) ? 32'(2) : (i < 12) ? 32'(4) : 32'(1));
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_grant", 32'(bus.grant), 32'(0));
    chk("async_rst_busy",  32'(bus.busy),  32'(0));
    chk("async_rst_num",   bus.num_out,    32'(10000));
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
